// File: rtl/dbg_pulse_meas_pkg.sv
// dbg_meas_pkg: shared types and defaults for the dbg_pulse_meas block.
//   state_t    - measurement FSM encoding (also exported on the debug state port)
//   CNT_W_DEF  - default width of the hi/lo length counters and result fields
//   TO_W_DEF   - default width of the no-edge watchdog counter
package dbg_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_t;

  localparam int CNT_W_DEF = 16;
  localparam int TO_W_DEF  = 20;

endpackage

// File: rtl/dbg_pulse_meas_if.sv
// dbg_pulse_meas_if: result handshake between the pulse measurer and its consumer.
//   Handshake rule: meas_valid rises with a new result; hi_len/lo_len/sat hold
//   stable while meas_valid=1; the consumer asserts meas_ack for one or more
//   cycles and the result is retired on the first clock edge where
//   meas_valid=1 and meas_ack=1. meas_ack while meas_valid=0 has no effect.
//   master - the measurer (drives valid and the result fields, reads ack)
//   slave  - the consumer  (reads valid and the result fields, drives ack)
interface dbg_pulse_meas_if #(
  parameter int CNT_W = 16
);
  logic             meas_valid;
  logic             meas_ack;
  logic [CNT_W-1:0] hi_len;
  logic [CNT_W-1:0] lo_len;
  logic             sat;

  modport master (output meas_valid, output hi_len, output lo_len, output sat,
                  input  meas_ack);
  modport slave  (input  meas_valid, input  hi_len, input  lo_len, input  sat,
                  output meas_ack);
endinterface

// File: rtl/dbg_pulse_meas_edge_det.sv
// dbg_edge_det: one-cycle edge detector for the toggle input.
//   clk, rst - clock and synchronous active-high reset
//   din      - toggle input, synchronous to clk
//   rise     - din is 1 now and was 0 last cycle
//   fall     - din is 0 now and was 1 last cycle
// d_q resets to 0, so a high input right after reset reads as a rise.
module dbg_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= din;
  end

  assign rise = din & ~d_q;
  assign fall = ~din & d_q;
endmodule

// File: rtl/dbg_pulse_meas.sv
// dbg_pulse_meas: measures the high and low phase of each dbg_in period in clk
// cycles and offers one result per period on a valid/ack handshake.
//   clk, rst   - clock and synchronous active-high reset
//   meas_en    - 1 = measure, 0 = idle with counters cleared (results kept)
//   dbg_in     - toggle input being measured
//   res        - result handshake (meas_valid/meas_ack/hi_len/lo_len/sat)
//   overrun    - sticky: a finished period was dropped while a result was pending
//   stuck      - no edge on dbg_in for TIMEOUT cycles while measuring
//   dbg_state  - current FSM state, for debug visibility
module dbg_pulse_meas
  import dbg_meas_pkg::*;
#(
  parameter int              CNT_W   = CNT_W_DEF,
  parameter int              TO_W    = TO_W_DEF,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(20'hFFFFF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    meas_en,
  input  logic                    dbg_in,
  dbg_pulse_meas_if.master        res,
  output logic                    overrun,
  output logic                    stuck,
  output state_t                  dbg_state
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST = TIMEOUT - TO_W'(1);

  state_t           state_q, state_d;
  logic             rise, fall;
  logic [CNT_W-1:0] hi_cnt, lo_cnt;
  logic             sat_pend;
  logic [TO_W-1:0]  wd_cnt;
  logic             active, timeout, capture;

  logic             valid_q, sat_q;
  logic [CNT_W-1:0] hi_len_q, lo_len_q;

  dbg_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (dbg_in),
    .rise (rise),
    .fall (fall)
  );

  assign active  = (state_q != ST_IDLE);
  // Fires on the TIMEOUT-th consecutive edge-free measuring cycle.
  assign timeout = meas_en & active & ~(rise | fall) & (wd_cnt == TO_LAST);
  // A rise seen in LO closes the period; the result registers load on this edge.
  assign capture = meas_en & (state_q == ST_LO) & rise;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!meas_en) begin
      state_d = ST_IDLE;
    end else if (timeout) begin
      state_d = ST_SYNC;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: if (rise) state_d = ST_HI;
        ST_HI:   if (fall) state_d = ST_LO;
        ST_LO:   if (rise) state_d = ST_HI;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Phase counters. The edge cycle itself counts toward the new phase, so
  // hi_len + lo_len equals the full period length.
  always_ff @(posedge clk) begin
    if (rst || !meas_en || timeout) begin
      hi_cnt   <= '0;
      lo_cnt   <= '0;
      sat_pend <= 1'b0;
    end else begin
      case (state_q)
        ST_SYNC, ST_LO: begin
          if (rise) begin
            hi_cnt   <= CNT_ONE;
            lo_cnt   <= '0;
            sat_pend <= 1'b0;
          end else if (state_q == ST_LO && !dbg_in) begin
            if (lo_cnt == CNT_MAX) sat_pend <= 1'b1;
            else                   lo_cnt   <= lo_cnt + CNT_ONE;
          end
        end
        ST_HI: begin
          if (fall) begin
            lo_cnt <= CNT_ONE;
          end else if (dbg_in) begin
            if (hi_cnt == CNT_MAX) sat_pend <= 1'b1;
            else                   hi_cnt   <= hi_cnt + CNT_ONE;
          end
        end
        default: begin
          hi_cnt   <= '0;
          lo_cnt   <= '0;
          sat_pend <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !meas_en || !active || rise || fall || timeout) wd_cnt <= '0;
    else                                                       wd_cnt <= wd_cnt + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)          stuck <= 1'b0;
    else if (timeout) stuck <= 1'b1;
    else if (rise)    stuck <= 1'b0;
  end

  // Result registers: a capture while an unacked result is pending is dropped
  // and flagged; a capture coinciding with ack replaces the retiring result.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      hi_len_q <= '0;
      lo_len_q <= '0;
      sat_q    <= 1'b0;
      overrun  <= 1'b0;
    end else if (capture) begin
      if (valid_q && !res.meas_ack) begin
        overrun <= 1'b1;
      end else begin
        valid_q  <= 1'b1;
        hi_len_q <= hi_cnt;
        lo_len_q <= lo_cnt;
        sat_q    <= sat_pend;
      end
    end else if (valid_q && res.meas_ack) begin
      valid_q <= 1'b0;
    end
  end

  assign res.meas_valid = valid_q;
  assign res.hi_len     = hi_len_q;
  assign res.lo_len     = lo_len_q;
  assign res.sat        = sat_q;
  assign dbg_state      = state_q;
endmodule
